// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port synchronous SRAM (1-cycle read
// latency, active-low CS/WE) between an instruction-fetch port and a data
// load/store port. A three-state response FSM tracks which access was issued
// last cycle so the matching ACK lines up with the SRAM read data.
//
// Optional build macro:
//   ARB_DPRIO_EN  - fixed priority, D wins every tie (default: round-robin).
//
// Memory-side and read-data outputs are combinational (suffix _c) because the
// SRAM must see the access in the grant cycle and its data is returned as-is.
module mem_port_arbiter #(
  parameter int unsigned AWIDTH = 14,
  parameter int unsigned DWIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  // instruction-fetch port
  input  logic                  i_req_i,
  input  logic [AWIDTH-1:0]     i_addr_i,
  output logic                  i_ack_o,
  output logic [DWIDTH-1:0]     i_rdata_c_o,
  // data load/store port
  input  logic                  d_req_i,
  input  logic                  d_we_i,
  input  logic [DWIDTH/8-1:0]   d_be_i,
  input  logic [AWIDTH-1:0]     d_addr_i,
  input  logic [DWIDTH-1:0]     d_wdata_i,
  output logic                  d_ack_o,
  output logic [DWIDTH-1:0]     d_rdata_c_o,
  // SRAM port
  output logic                  mem_csn_c_o,
  output logic                  mem_wen_c_o,
  output logic [DWIDTH/8-1:0]   mem_be_c_o,
  output logic [AWIDTH-3:0]     mem_addr_c_o,
  output logic [DWIDTH-1:0]     mem_di_c_o,
  input  logic [DWIDTH-1:0]     mem_dout_i,
  // performance
  output logic [31:0]           stall_cnt_o
);

  localparam int unsigned BE_W  = DWIDTH / 8;
  localparam int unsigned WA_W  = AWIDTH - 2;
  localparam int unsigned CNT_W = 32;

  // LAST encoding: which port received the most recent grant
  localparam logic LAST_I = 1'b0;
  localparam logic LAST_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RESP_I = 2'd1,
    RESP_D = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic               last_q, last_d;
  logic               i_ack_q, i_ack_d;
  logic               d_ack_q, d_ack_d;
  logic [CNT_W-1:0]   stall_q, stall_d;

  logic               i_elig, d_elig;
  logic               gnt_i, gnt_d;

  logic               mem_csn;
  logic               mem_wen;
  logic [BE_W-1:0]    mem_be;
  logic [WA_W-1:0]    mem_addr;
  logic [DWIDTH-1:0]  mem_di;

  // Byte-offset address bits are ignored by a word-wide SRAM.
  logic               unused_addr_lsbs;
  assign unused_addr_lsbs = ^{i_addr_i[1:0], d_addr_i[1:0]};

  // State, tie-break history, ACK pulses and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= LAST_D;
      i_ack_q <= 1'b0;
      d_ack_q <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      i_ack_q <= i_ack_d;
      d_ack_q <= d_ack_d;
      stall_q <= stall_d;
    end
  end

  // Eligibility, grant, next state, SRAM drive and stall accounting.
  always_comb begin
    state_d  = IDLE;
    last_d   = last_q;
    gnt_i    = 1'b0;
    gnt_d    = 1'b0;
    mem_csn  = 1'b1;
    mem_wen  = 1'b1;
    mem_be   = '0;
    mem_addr = '0;
    mem_di   = '0;
    stall_d  = stall_q;

    // A port still in its ACK cycle may hold REQ high; do not re-issue it.
    // rst_n gating keeps the SRAM idle while reset is held.
    i_elig = rst_n & i_req_i & (state_q != RESP_I);
    d_elig = rst_n & d_req_i & (state_q != RESP_D);

    if (i_elig && d_elig) begin
`ifdef ARB_DPRIO_EN
      gnt_d = 1'b1;
`else
      if (last_q == LAST_D) begin
        gnt_i = 1'b1;
      end else begin
        gnt_d = 1'b1;
      end
`endif
    end else begin
      gnt_i = i_elig;
      gnt_d = d_elig;
    end

    if (gnt_i) begin
      state_d  = RESP_I;
      last_d   = LAST_I;
      mem_csn  = 1'b0;
      mem_wen  = 1'b1;
      mem_be   = '0;
      mem_addr = i_addr_i[AWIDTH-1:2];
    end else if (gnt_d) begin
      state_d  = RESP_D;
      last_d   = LAST_D;
      mem_csn  = 1'b0;
      mem_wen  = ~d_we_i;
      mem_be   = d_we_i ? d_be_i : '0;
      mem_addr = d_addr_i[AWIDTH-1:2];
      mem_di   = d_wdata_i;
    end

    // A fetch is waiting when it is neither issued nor being acknowledged.
    if (i_req_i && !gnt_i && (state_q != RESP_I) && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  // ACK pulses follow the grant by exactly one cycle.
  always_comb begin
    i_ack_d = (state_d == RESP_I);
    d_ack_d = (state_d == RESP_D);
  end

  assign i_ack_o      = i_ack_q;
  assign d_ack_o      = d_ack_q;
  assign i_rdata_c_o  = mem_dout_i;
  assign d_rdata_c_o  = mem_dout_i;
  assign mem_csn_c_o  = mem_csn;
  assign mem_wen_c_o  = mem_wen;
  assign mem_be_c_o   = mem_be;
  assign mem_addr_c_o = mem_addr;
  assign mem_di_c_o   = mem_di;
  assign stall_cnt_o  = stall_q;

endmodule
